// File: rtl/v810_bus_pkg.sv
// Shared state type, V810 cycle-status encodings and lane helpers for the bus target.
package v810_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2,
        READY  = 2'd3
    } bus_state_e;

    localparam logic [1:0] ST_IO      = 2'b10;  // ST code of an I/O cycle
    localparam int         ST_ACK_BIT = 0;      // ST bit set on halt / fault acknowledge
    localparam int         WAIT_W     = 4;      // wait counter width (0..15 wait states)

    // High-true lane enables of a 16-bit device: the halfword selected by A[1]
    // lands in lanes 1:0 (A[1]=0) or lanes 3:2 (A[1]=1).
    function automatic logic [3:0] bus16_be(input logic a1, input logic [3:0] ben);
        return a1 ? {~ben[3:2], 2'b00} : {2'b00, ~ben[1:0]};
    endfunction

endpackage

// File: rtl/v810_wait_ctr.sv
// Minimum wait-state counter: loads on cycle start, counts down while enabled,
// saturates at zero and flags it.
module v810_wait_ctr
    import v810_bus_pkg::*;
#(
    parameter int W = WAIT_W
)(
    input  logic         clk,
    input  logic         res,
    input  logic         ce,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt <= '0;
        end else if (ce) begin
            if (load)
                cnt <= load_val;
            else if (dec && cnt != '0)
                cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/v810_bus_target.sv
// V810 external-bus target: decodes a bus cycle, runs it against a simple
// request/acknowledge backend, and returns READYn (plus SZRQn for 16-bit mode).
module v810_bus_target
    import v810_bus_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h8000_0000,
    parameter logic [31:0] MASK        = 32'h8000_0000,
    parameter int          WAIT_STATES = 0,
    parameter bit          BUS16       = 1'b0,
    parameter bit          IO_SPACE    = 1'b0
)(
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [31:0] A,
    input  logic [31:0] D_I,
    output logic [31:0] D_O,
    input  logic [3:0]  BEn,
    input  logic [1:0]  ST,
    input  logic        DAn,
    input  logic        MRQn,
    input  logic        RW,
    input  logic        BCYSTn,
    output logic        READYn,
    output logic        SZRQn,
    output logic [29:0] MEM_A,
    output logic [3:0]  MEM_BE,
    output logic        MEM_WE,
    output logic [31:0] MEM_WD,
    output logic        MEM_REQ,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RD
);

    bus_state_e  state, state_nx;
    logic [31:1] a_q;          // A[0] carries no information on this bus
    logic [3:0]  ben_q;
    logic        rw_q;
    logic        szrq_q;       // 32-bit access to a 16-bit device: ask for a split
    logic [31:0] d_q;
    logic [31:0] rd_q;
    logic        type_ok, sel, start, in_cycle, ctr_zero;
    logic [3:0]  be_map;
    logic [31:0] wd_map, do_map;
    logic        unused_a0;

    assign unused_a0 = A[0];

    // Cycle-type match; halt/fault acknowledge never selects.
    assign type_ok  = IO_SPACE ? (MRQn && ST == ST_IO) : !MRQn;
    assign sel      = ((A & MASK) == (BASE & MASK)) && type_ok && !(MRQn && ST[ST_ACK_BIT]);
    assign start    = (state == IDLE) && !BCYSTn && sel;
    assign in_cycle = (state == ACCESS) || (state == HOLD);

    // Lane steering from latched request only, so nothing on A/BEn/D_I reaches outputs directly.
    assign be_map = BUS16 ? bus16_be(a_q[1], ben_q) : ~ben_q;
    assign wd_map = !BUS16 ? d_q :
                    a_q[1] ? {d_q[15:0], 16'h0000} : {16'h0000, d_q[15:0]};
    assign do_map = !BUS16 ? rd_q :
                    a_q[1] ? {16'h0000, rd_q[31:16]} : {16'h0000, rd_q[15:0]};

    v810_wait_ctr #(.W(WAIT_W)) u_wait (
        .clk      (CLK),
        .res      (RES),
        .ce       (CE),
        .load     (start),
        .load_val (WAIT_W'(WAIT_STATES)),
        .dec      (in_cycle),
        .zero     (ctr_zero)
    );

    // State register; reset wins over the clock enable.
    always_ff @(posedge CLK) begin
        if (RES)
            state <= IDLE;
        else if (CE)
            state <= state_nx;
    end

    // Latch the CPU request when the cycle is accepted; capture read data on acknowledge.
    always_ff @(posedge CLK) begin
        if (RES) begin
            a_q    <= '0;
            ben_q  <= '0;
            rw_q   <= 1'b0;
            szrq_q <= 1'b0;
            d_q    <= '0;
            rd_q   <= '0;
        end else if (CE) begin
            if (start) begin
                a_q    <= A[31:1];
                ben_q  <= BEn;
                rw_q   <= RW;
                d_q    <= D_I;
                szrq_q <= BUS16 && !A[1] && (BEn == 4'b0000);
            end
            if (state == ACCESS && MEM_ACK && !DAn)
                rd_q <= MEM_RD;
        end
    end

    // Next state and state-decoded outputs; a DAn release aborts ahead of any acknowledge.
    always_comb begin
        state_nx = state;
        READYn   = 1'b1;
        SZRQn    = 1'b1;
        D_O      = '0;
        MEM_REQ  = 1'b0;
        MEM_A    = '0;
        MEM_BE   = '0;
        MEM_WE   = 1'b0;
        MEM_WD   = '0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = ACCESS;
            end
            ACCESS: begin
                MEM_REQ = 1'b1;
                MEM_A   = a_q[31:2];
                MEM_BE  = be_map;
                MEM_WE  = !rw_q;
                MEM_WD  = wd_map;
                if (DAn)
                    state_nx = IDLE;
                else if (MEM_ACK)
                    state_nx = ctr_zero ? READY : HOLD;
            end
            HOLD: begin
                if (DAn)
                    state_nx = IDLE;
                else if (ctr_zero)
                    state_nx = READY;
            end
            READY: begin
                READYn   = 1'b0;
                SZRQn    = !szrq_q;
                if (rw_q)
                    D_O = do_map;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_v810_bus_target.sv
// Randomized bench for v810_bus_target: five configurations share one CPU bus and
// backend; a transaction-level model predicts each one's outputs per enabled cycle.
module tb_v810_bus_target;

    localparam int N = 5;
    // per instance: 0 plain W=0, 1 W=3, 2 W=7, 3 16-bit W=2, 4 I/O space W=1
    localparam logic [N-1:0][3:0] WS  = {4'd1, 4'd2, 4'd7, 4'd3, 4'd0};
    localparam logic [N-1:0]      B16 = 5'b01000;
    localparam logic [N-1:0]      IOS = 5'b10000;

    logic        clk = 1'b0;
    logic        res, ce, dan, mrqn, rw, bcystn, mem_ack;
    logic [31:0] a, d_i, mem_rd;
    logic [3:0]  ben;
    logic [1:0]  st;

    logic [31:0] d_o    [N];
    logic        readyn [N];
    logic        szrqn  [N];
    logic [29:0] mem_a  [N];
    logic [3:0]  mem_be [N];
    logic        mem_we [N];
    logic [31:0] mem_wd [N];
    logic        mem_req[N];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        v810_bus_target #(
            .BASE        (32'h8000_0000),
            .MASK        (32'h8000_0000),
            .WAIT_STATES (int'(WS[g])),
            .BUS16       (B16[g]),
            .IO_SPACE    (IOS[g])
        ) u_dut (
            .CLK     (clk),
            .RES     (res),
            .CE      (ce),
            .A       (a),
            .D_I     (d_i),
            .D_O     (d_o[g]),
            .BEn     (ben),
            .ST      (st),
            .DAn     (dan),
            .MRQn    (mrqn),
            .RW      (rw),
            .BCYSTn  (bcystn),
            .READYn  (readyn[g]),
            .SZRQn   (szrqn[g]),
            .MEM_A   (mem_a[g]),
            .MEM_BE  (mem_be[g]),
            .MEM_WE  (mem_we[g]),
            .MEM_WD  (mem_wd[g]),
            .MEM_REQ (mem_req[g]),
            .MEM_ACK (mem_ack),
            .MEM_RD  (mem_rd)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One CPU bus cycle starting with BCYSTn in logical cycle 0. k = cycle of the
    // single backend acknowledge (>=1); ab = DAn release cycle; sp = stray BCYSTn
    // cycle; rs = reset cycle (0 = none). Logical cycles advance only on CE=1 edges.
    task automatic run_txn(input logic [31:0] addr, input logic mq, input logic [1:0] s,
                           input logic r_w, input logic [3:0] be, input logic [31:0] wd,
                           input logic [31:0] rdv, input int k, input int ab,
                           input int sp, input int rs);
        bit          sel [N];
        int          rc  [N];
        int          len, max_r;
        logic [31:0] rnd;
        max_r = 0;
        for (int i = 0; i < N; i++) begin
            sel[i] = ((addr & 32'h8000_0000) == 32'h8000_0000) &&
                     (IOS[i] ? (mq && s == 2'b10) : !mq);
            // ready one cycle after both the acknowledge and the minimum wait are done
            rc[i]  = ((k > int'(WS[i]) + 1) ? k : int'(WS[i]) + 1) + 1;
            if (rc[i] > max_r) max_r = rc[i];
        end
        len = (rs != 0) ? rs + 20 : max_r + 1;
        for (int c = 0; c <= len; c++) begin
            rnd     = $urandom();
            bcystn  = !(c == 0 || (sp != 0 && c == sp));
            a       = (c == 0) ? addr : {addr[31], rnd[30:0]};
            d_i     = (c == 0) ? wd : $urandom();
            ben     = (c == 0) ? be : 4'($urandom());
            rw      = (c == 0) ? r_w : 1'($urandom());
            mrqn    = mq;
            st      = s;
            dan     = (ab != 0 && c >= ab);
            mem_ack = (c == k) || ((c == 0 || c > k) && $urandom_range(0, 1) == 1);
            mem_rd  = (c == k) ? rdv : $urandom();
            #1;
            for (int i = 0; i < N; i++) begin
                bit          act, e_req, e_rdy;
                logic [3:0]  ebe;
                string       t;
                t     = $sformatf("u%0d c%0d", i, c);
                act   = sel[i] && !(rs != 0 && c > rs);
                e_req = act && c >= 1 && c <= ((ab != 0) ? ab : k);
                e_rdy = act && ab == 0 && c == rc[i];
                if (!B16[i])     ebe = ~be;
                else if (addr[1]) ebe = {~be[3:2], 2'b00};
                else             ebe = {2'b00, ~be[1:0]};
                chk({t, " readyn"}, 32'(readyn[i]), 32'(!e_rdy));
                chk({t, " mem_req"}, 32'(mem_req[i]), 32'(e_req));
                chk({t, " szrqn"}, 32'(szrqn[i]),
                    32'(!(e_rdy && B16[i] && !addr[1] && be == 4'b0000)));
                if (e_rdy && r_w) begin
                    if (B16[i])
                        chk({t, " d_o16"}, 32'(d_o[i][15:0]), 32'(addr[1] ? rdv[31:16] : rdv[15:0]));
                    else
                        chk({t, " d_o"}, d_o[i], rdv);
                end else begin
                    chk({t, " d_o idle"}, d_o[i], 32'd0);
                end
                if (e_req) begin
                    chk({t, " mem_a"}, 32'(mem_a[i]), 32'(addr[31:2]));
                    chk({t, " mem_we"}, 32'(mem_we[i]), 32'(!r_w));
                    chk({t, " mem_be"}, 32'(mem_be[i]), 32'(ebe));
                    if (!r_w) begin
                        if (!B16[i])      chk({t, " mem_wd"}, mem_wd[i], wd);
                        else if (addr[1]) chk({t, " mem_wd_hi"}, 32'(mem_wd[i][31:16]), 32'(wd[15:0]));
                        else              chk({t, " mem_wd_lo"}, 32'(mem_wd[i][15:0]), 32'(wd[15:0]));
                    end
                end else if (!act || c == 0) begin
                    chk({t, " mem_be idle"}, 32'(mem_be[i]), 32'd0);
                    chk({t, " mem_we idle"}, 32'(mem_we[i]), 32'd0);
                end
            end
            if (rs != 0 && c == rs) begin
                res = 1'b1;
                ce  = 1'($urandom_range(0, 1));
                @(posedge clk); @(negedge clk);
                res = 1'b0;
            end else begin
                ce = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); @(negedge clk);
                end
                ce = 1'b1;
                @(posedge clk); @(negedge clk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with CE low and a selectable start on the bus: reset must still win
        res = 1'b1; ce = 1'b0; a = 32'h8000_0010; d_i = '0; ben = '0; st = 2'b00;
        dan = 1'b0; mrqn = 1'b0; rw = 1'b1; bcystn = 1'b0; mem_ack = 1'b1; mem_rd = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d rst readyn", i), 32'(readyn[i]), 32'd1);
            chk($sformatf("u%0d rst szrqn", i), 32'(szrqn[i]), 32'd1);
            chk($sformatf("u%0d rst d_o", i), d_o[i], 32'd0);
            chk($sformatf("u%0d rst mem_req", i), 32'(mem_req[i]), 32'd0);
            chk($sformatf("u%0d rst mem_we", i), 32'(mem_we[i]), 32'd0);
            chk($sformatf("u%0d rst mem_be", i), 32'(mem_be[i]), 32'd0);
        end
        res = 1'b0; bcystn = 1'b1; ce = 1'b1;
        @(posedge clk); @(negedge clk);

        // zero-wait read with immediate acknowledge
        run_txn(32'h8000_0010, 1'b0, 2'b00, 1'b1, 4'b0000, 32'h0, 32'hDEADBEEF, 1, 0, 0, 0);
        // three-wait write of the low two lanes
        run_txn(32'h8000_0040, 1'b0, 2'b00, 1'b0, 4'b1100, 32'h12345678, 32'h0, 1, 0, 0, 0);
        // 16-bit device: word read split into two halfword transfers
        run_txn(32'h8000_0020, 1'b0, 2'b00, 1'b1, 4'b0000, 32'h0, 32'hAAAA5555, 2, 0, 0, 0);
        run_txn(32'h8000_0022, 1'b0, 2'b00, 1'b1, 4'b0011, 32'h0, 32'hAAAA5555, 1, 0, 0, 0);
        // 16-bit upper-half write
        run_txn(32'h8000_0032, 1'b0, 2'b00, 1'b0, 4'b0011, 32'h0000_BEEF, 32'h0, 1, 0, 0, 0);
        // I/O cycle, then halt acknowledge that nobody may answer
        run_txn(32'h8000_0100, 1'b1, 2'b10, 1'b1, 4'b0000, 32'h0, 32'h0BAD_F00D, 3, 0, 0, 0);
        run_txn(32'h8000_0104, 1'b1, 2'b01, 1'b1, 4'b0000, 32'h0, 32'h0, 1, 0, 0, 0);
        // reset while the seven-wait instance sits in HOLD
        run_txn(32'h8000_0200, 1'b0, 2'b00, 1'b1, 4'b0000, 32'h0, 32'h5A5A5A5A, 1, 0, 0, 3);
        // address outside the decoded window
        run_txn(32'h0000_0010, 1'b0, 2'b00, 1'b1, 4'b0000, 32'h0, 32'h0, 1, 0, 0, 0);
        // DAn release before the acknowledge, and a stray BCYSTn mid-cycle
        run_txn(32'h8000_0300, 1'b0, 2'b00, 1'b0, 4'b0000, 32'hCAFE0001, 32'h0, 4, 2, 0, 0);
        run_txn(32'h8000_0400, 1'b0, 2'b00, 1'b1, 4'b1000, 32'h0, 32'h1357_9BDF, 3, 0, 2, 0);

        for (int n = 0; n < 120; n++) begin
            logic [31:0] ra;
            int          k, mode, ab, sp, rs;
            ra = $urandom();
            if ($urandom_range(0, 3) != 0) ra[31] = 1'b1;
            k    = int'($urandom_range(1, 10));
            mode = int'($urandom_range(0, 9));
            ab   = (mode == 0) ? int'($urandom_range(1, k)) : 0;
            sp   = (mode == 1) ? int'($urandom_range(1, k)) : 0;
            rs   = (mode == 2) ? int'($urandom_range(1, 12)) : 0;
            run_txn(ra, 1'($urandom_range(0, 1)), 2'($urandom()), 1'($urandom()),
                    4'($urandom()), $urandom(), $urandom(), k, ab, sp, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/v810_bus_target.md
V810_BUS_TARGET -- requirements
Module: v810_bus_target

Interface
REQ-001 Parameters SHALL be: BASE 32'h8000_0000 (decode base); MASK 32'h8000_0000 (address bits compared); WAIT_STATES 0 (minimum wait cycles, 0..15); BUS16 0 (1 = behave as 16-bit device); IO_SPACE 0 (1 = respond to I/O cycles instead of memory cycles).
REQ-002 Clock and control ports SHALL be: CLK in 1 clock; RES in 1 synchronous active-high reset; CE in 1 clock enable.
REQ-003 V810 external bus ports SHALL be: A in 32 address; D_I in 32 write data from CPU; D_O out 32 read data to CPU; BEn in 4 byte enables (low-true); ST in 2 cycle status; DAn in 1 data phase strobe; MRQn in 1 memory request; RW in 1 (1=read); BCYSTn in 1 bus cycle start; READYn out 1; SZRQn out 1.
REQ-004 Backend ports SHALL be: MEM_A out 30 word address; MEM_BE out 4 byte enables (high-true); MEM_WE out 1; MEM_WD out 32; MEM_REQ out 1; MEM_ACK in 1; MEM_RD in 32.

Function
REQ-005 All state SHALL advance only on CLK rising edges where CE=1.
REQ-006 Select = ((A & MASK) == (BASE & MASK)) and cycle-type match: memory cycle MRQn=0 (IO_SPACE=0); I/O cycle MRQn=1 with ST=2'b10 (IO_SPACE=1); MRQn=1 with ST[0]=1 (halt/fault acknowledge) SHALL never select.
REQ-007 FSM states SHALL be IDLE, ACCESS, HOLD, READY.
REQ-008 IDLE->ACCESS when BCYSTn=0 and select; A, BEn, RW, D_I latched that cycle.
REQ-009 ACCESS: MEM_REQ=1 with latched controls until MEM_ACK=1 sampled; wait counter loads WAIT_STATES on entry and decrements each CE cycle, saturating at 0.
REQ-010 ACCESS->READY when MEM_ACK=1 and counter=0; ACCESS->HOLD when MEM_ACK=1 and counter>0; HOLD->READY when counter reaches 0; MEM_REQ=0 in HOLD.
REQ-011 READY lasts exactly one CE cycle: READYn=0, D_O = registered MEM_RD (reads), then ->IDLE; with WAIT_STATES=0 and MEM_ACK in the first ACCESS cycle, READYn SHALL be low in the 2nd CE cycle after BCYSTn.
REQ-012 Outside READY: READYn=1, SZRQn=1, D_O=0.
REQ-013 MEM_A = latched A[31:2]; MEM_BE = ~latched BEn; MEM_WE = ~latched RW; MEM_WD = latched D_I (BUS16=0).
REQ-014 BUS16=1, latched A[1]=0, all four BEn low: only lanes 1:0 accessed (MEM_BE=4'b0011), SZRQn=0 together with READYn=0.
REQ-015 BUS16=1 halfword data SHALL use D[15:0]: A[1]=0 maps to MEM_WD/MEM_RD[15:0]; A[1]=1 maps D_I[15:0] to MEM_WD[31:16], MEM_RD[31:16] to D_O[15:0], MEM_BE = {~BEn[3:2],2'b00}.
REQ-016 BCYSTn=0 while not IDLE SHALL be ignored; DAn=1 in ACCESS or HOLD SHALL abort to IDLE, MEM_REQ dropped next cycle, READYn never asserted.
REQ-017 MEM_ACK outside ACCESS SHALL be ignored.
REQ-018 An unselected cycle SHALL leave all outputs at idle values for the whole cycle.

Reset
REQ-019 RES=1 at a CLK edge SHALL force IDLE, READYn=1, SZRQn=1, D_O=0, MEM_REQ=0, MEM_WE=0, MEM_BE=0, counter=0, regardless of CE.
REQ-020 Reset mid-ACCESS/HOLD/READY SHALL abandon the cycle; no READYn pulse after RES deasserts.

Structure
REQ-021 FSM state enum, ST encodings (I/O 2'b10, ack mask bit 0) SHALL reside in shared package v810_bus_pkg.
REQ-022 Wait counter SHALL be sub-module v810_wait_ctr (load, CE-gated decrement, zero flag).
REQ-023 No combinational path from A/BEn/D_I to READYn, SZRQn or D_O.

Verification
REQ-024 WAIT_STATES=0, read A=32'h8000_0010, MEM_ACK same cycle, MEM_RD=32'hDEADBEEF -> READYn low 2nd cycle after BCYSTn, D_O=32'hDEADBEEF, MEM_A=30'h2000_0004.
REQ-025 WAIT_STATES=3, write D_I=32'h12345678, BEn=4'b1100 -> MEM_WE=1, MEM_BE=4'b0011, READYn low exactly 1 cycle, 5th cycle after BCYSTn.
REQ-026 BUS16=1, word read A=32'h8000_0020 then CPU second transfer A=32'h8000_0022, MEM_RD=32'hAAAA5555 -> first: SZRQn=0, D_O[15:0]=16'h5555; second: SZRQn=1, D_O[15:0]=16'hAAAA.
REQ-027 IO_SPACE=1: I/O cycle (MRQn=1, ST=2'b10) serviced; memory cycle and halt ack (MRQn=1, ST=2'b01) -> READYn stays 1, MEM_REQ stays 0.
REQ-028 RES=1 during HOLD with WAIT_STATES=7 -> next cycle MEM_REQ=0, READYn=1, no READYn pulse for 20 cycles after RES=0.
REQ-029 A=32'h0000_0010 (outside MASK/BASE) -> no MEM_REQ, READYn=1 throughout.
